alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one ready/valid ALU datapath (operands A, B; result Y) between N_REQ requesters using round-robin arbitration.
- One transaction is outstanding at a time. The block accepts an operand pair, issues it to the ALU, captures the result and routes it back to the originating requester.
- Sits between the requester-side generators and the ALU instance. Its ALU-side ports connect directly to the ALU's i_VALID/o_READY/o_VALID/i_READY.

Parameters:
- N_REQ, 2, number of requesters (>=1).
- WIDTH, 4, operand and result width in bits.
- ID_W, $clog2(N_REQ) (min 1), width of the owner index.

Ports:
- i_CLK  in  1  clock; all logic is rising-edge.
- i_RST  in  1  synchronous, active-high reset.
- i_REQ_VALID  in  N_REQ  per-requester operand valid.
- o_REQ_READY  out  N_REQ  per-requester accept; one-hot or zero.
- i_REQ_A  in  N_REQ*WIDTH  packed operand A; requester k uses bits [k*WIDTH +: WIDTH].
- i_REQ_B  in  N_REQ*WIDTH  packed operand B; same packing as i_REQ_A.
- o_RSP_VALID  out  N_REQ  per-requester result valid; one-hot or zero.
- i_RSP_READY  in  N_REQ  per-requester result accept.
- o_RSP_Y  out  WIDTH  result, shared by all requesters.
- o_ALU_VALID  out  1  operands valid toward the ALU.
- i_ALU_READY  in  1  ALU accepts operands.
- o_ALU_A  out  WIDTH  registered operand A.
- o_ALU_B  out  WIDTH  registered operand B.
- i_ALU_VALID  in  1  ALU result valid.
- o_ALU_READY  out  1  block accepts the ALU result.
- i_ALU_Y  in  WIDTH  ALU result.
- o_BUSY  out  1  high in any state other than IDLE.
- o_OWNER  out  ID_W  index of the current/last granted requester.

Behaviour:
- Reset (i_RST high at a clock edge): state=IDLE, ptr=N_REQ-1, owner=0, A/B/Y registers=0. All valid/ready outputs 0, o_BUSY=0, o_OWNER=0. Reset mid-transaction abandons it with no response; the ALU must be reset in the same cycle.
- Handshake: a transfer occurs on a clock edge where valid and ready are both high. Sources hold valid and data stable until that transfer; dropping valid early is a protocol violation and is not handled.
- Ready/valid outputs are driven only by the state below and are 0 in every other state.
- FSM states: IDLE, ISSUE, WAIT_RSP, DELIVER.
- IDLE
  - Winner = first k with i_REQ_VALID[k]=1, searching ptr+1, ptr+2, ... modulo N_REQ.
  - o_REQ_READY is combinational: one-hot at the winner, zero if no request.
  - On the handshake edge: latch A/B from the winner, owner=winner, go to ISSUE.
- ISSUE
  - o_ALU_VALID=1, o_ALU_A/o_ALU_B = registered operands.
  - On i_ALU_READY: go to WAIT_RSP.
- WAIT_RSP
  - o_ALU_READY=1.
  - On i_ALU_VALID: latch i_ALU_Y, go to DELIVER.
  - i_ALU_VALID is ignored in all other states.
- DELIVER
  - o_RSP_VALID[owner]=1, o_RSP_Y = latched Y.
  - On i_RSP_READY[owner]: ptr=owner, go to IDLE.
  - i_RSP_READY of non-owners is ignored.
- Latency: request accepted at edge T; o_ALU_VALID high in cycle T+1. If the ALU result is accepted at edge R, o_RSP_VALID is high from cycle R+1.
- Fairness: a continuously requesting requester is granted within N_REQ transactions. Pointer wrap: owner N_REQ-1 makes requester 0 first candidate.
- Simultaneous requests: exactly one granted; the others see ready=0 and keep valid.
- No new request is accepted before the response handshake completes, so throughput is at most one transaction per 4 cycles.
- o_RSP_Y, o_ALU_A, o_ALU_B are register outputs and hold their last values when not valid.
- N_REQ=1: arbitration degenerates, the FSM is unchanged, ID_W=1 and owner is always 0.

Test Plan:
- Reset, then release with no requests: all outputs 0, o_BUSY=0, state stays IDLE, o_REQ_READY=00.
- Single request, N_REQ=2, req1 A=4'h3 B=4'h5, ALU ready immediately, ALU returns Y=4'h8 one cycle later:
  - o_REQ_READY=10 in the accept cycle.
  - o_ALU_VALID at T+1 with A=3, B=5.
  - o_RSP_VALID=10 with Y=8.
  - o_OWNER=1.
- Both requesters valid continuously from reset: grants alternate 0,1,0,1 (ptr starts at 1); each requester receives its own result.
- ALU backpressure: hold i_ALU_READY=0 for 5 cycles in ISSUE. o_ALU_VALID stays 1 with A/B unchanged, and no o_REQ_READY is asserted during that time.
- Response backpressure: hold i_RSP_READY[owner]=0 for 3 cycles while the other requester is valid. o_RSP_VALID and Y stay stable, and the other requester is not accepted until the response completes.
- Assert i_RST in WAIT_RSP: next cycle state=IDLE, all valid/ready outputs 0, ptr=N_REQ-1; the next simultaneous request grants requester 0.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one ready/valid ALU among N_REQ requesters, round-robin,
// one transaction in flight, result routed back to the granted requester.
module alu_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic [N_REQ-1:0]       i_REQ_VALID,
  output logic [N_REQ-1:0]       o_REQ_READY,
  input  logic [N_REQ*WIDTH-1:0] i_REQ_A,
  input  logic [N_REQ*WIDTH-1:0] i_REQ_B,
  output logic [N_REQ-1:0]       o_RSP_VALID,
  input  logic [N_REQ-1:0]       i_RSP_READY,
  output logic [WIDTH-1:0]       o_RSP_Y,
  output logic                   o_ALU_VALID,
  input  logic                   i_ALU_READY,
  output logic [WIDTH-1:0]       o_ALU_A,
  output logic [WIDTH-1:0]       o_ALU_B,
  input  logic                   i_ALU_VALID,
  output logic                   o_ALU_READY,
  input  logic [WIDTH-1:0]       i_ALU_Y,
  output logic                   o_BUSY,
  output logic [ID_W-1:0]        o_OWNER
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;
  state_t r_state, w_next;
  logic [ID_W-1:0] r_ptr, r_owner, w_win;
  logic [WIDTH-1:0] r_a, r_b, r_y;
  logic w_found, w_accept, w_done;
  int w_best, w_dist;
  // Winner is the valid requester at the smallest rotational distance past ptr.
  always_comb begin
    w_best = N_REQ;
    w_win = '0;
    w_dist = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_dist = (k + N_REQ - 1 - int'(r_ptr)) % N_REQ;
      if (i_REQ_VALID[k] && w_dist < w_best) begin
        w_best = w_dist;
        w_win = ID_W'(k);
      end
    end
  end
  assign w_found  = w_best < N_REQ;
  assign w_accept = (r_state == IDLE) && w_found;
  assign w_done   = (r_state == DELIVER) && i_RSP_READY[r_owner];
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_found ? ISSUE : IDLE;
      ISSUE:    w_next = i_ALU_READY ? WAIT_RSP : ISSUE;
      WAIT_RSP: w_next = i_ALU_VALID ? DELIVER : WAIT_RSP;
      DELIVER:  w_next = i_RSP_READY[r_owner] ? IDLE : DELIVER;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= IDLE;
      r_ptr   <= ID_W'(N_REQ - 1);
      r_owner <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= i_REQ_A[w_win*WIDTH +: WIDTH];
        r_b     <= i_REQ_B[w_win*WIDTH +: WIDTH];
        r_owner <= w_win;
      end
      if (r_state == WAIT_RSP && i_ALU_VALID) r_y <= i_ALU_Y;
      if (w_done) r_ptr <= r_owner;
    end
  end
  assign o_REQ_READY = w_accept ? N_REQ'(1) << w_win : '0;
  assign o_RSP_VALID = (r_state == DELIVER) ? N_REQ'(1) << r_owner : '0;
  assign o_ALU_VALID = r_state == ISSUE;
  assign o_ALU_READY = r_state == WAIT_RSP;
  assign o_BUSY      = r_state != IDLE;
  assign o_OWNER     = r_owner;
  assign o_ALU_A     = r_a;
  assign o_ALU_B     = r_b;
  assign o_RSP_Y     = r_y;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed protocol checks plus a queue scoreboard against a
// round-robin reference model, with an adder standing in for the ALU.
module tb_alu_rr_arbiter;
  localparam int N = 2;
  localparam int W = 4;
  typedef struct {int id; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] y;} exp_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready, hs_req;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0] rsp_y, alu_a, alu_b, alu_y, cap_a, cap_b, alu_res;
  logic alu_valid_o, alu_ready_i, alu_valid_i, alu_ready_o, busy, hs_ai, hs_ao;
  logic [0:0] owner;
  logic rand_on = 0, sb_on = 0, cont = 0, alu_pend = 0;
  int n_chk = 0, n_err = 0, n_acc = 0, n_pop = 0, n_done = 0, m_ptr = N - 1;
  exp_t exp_q[$];
  int own_log[$];

  alu_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .i_CLK(clk), .i_RST(rst), .i_REQ_VALID(req_valid), .o_REQ_READY(req_ready),
    .i_REQ_A(req_a), .i_REQ_B(req_b), .o_RSP_VALID(rsp_valid), .i_RSP_READY(rsp_ready),
    .o_RSP_Y(rsp_y), .o_ALU_VALID(alu_valid_o), .i_ALU_READY(alu_ready_i),
    .o_ALU_A(alu_a), .o_ALU_B(alu_b), .i_ALU_VALID(alu_valid_i), .o_ALU_READY(alu_ready_o),
    .i_ALU_Y(alu_y), .o_BUSY(busy), .o_OWNER(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random/continuous stimulus: requesters hold until accepted, ALU is an adder.
  always begin
    @(negedge clk);
    hs_req = req_ready & req_valid;
    hs_ai = alu_valid_o & alu_ready_i;
    hs_ao = alu_ready_o & alu_valid_i;
    cap_a = alu_a;
    cap_b = alu_b;
    @(posedge clk);
    #1;
    if (rand_on) begin
      for (int k = 0; k < N; k++)
        if (!req_valid[k] || hs_req[k]) begin
          req_valid[k] = cont || ($urandom_range(0, 2) != 0);
          req_a[k*W +: W] = W'($urandom);
          req_b[k*W +: W] = W'($urandom);
        end
      alu_ready_i = cont || ($urandom_range(0, 2) == 0);
      if (hs_ai) begin
        alu_pend = 1;
        alu_res = cap_a + cap_b;
      end
      if (hs_ao) alu_valid_i = 0;
      if (alu_pend && !alu_valid_i && (cont || $urandom_range(0, 1) == 1)) begin
        alu_valid_i = 1;
        alu_y = alu_res;
        alu_pend = 0;
      end
      rsp_ready = cont ? '1 : N'($urandom);
    end
  end

  // Reference model: when free, the first valid requester after the last owner wins.
  always @(negedge clk) if (sb_on) begin
    int win;
    logic [N-1:0] er;
    exp_t e;
    win = -1;
    er = '0;
    if (n_acc == n_pop)
      for (int s = 1; s <= N; s++)
        if (win < 0 && req_valid[(m_ptr + s) % N]) win = (m_ptr + s) % N;
    if (win >= 0) er[win] = 1'b1;
    chk("req_ready", req_ready, er);
    if (win >= 0) begin
      e.id = win;
      e.a = req_a[win*W +: W];
      e.b = req_b[win*W +: W];
      e.y = e.a + e.b;
      exp_q.push_back(e);
      n_acc++;
    end
  end

  // Monitor: checks ALU issue and response delivery against the queue head.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (sb_on) begin
      if (alu_valid_o && alu_ready_i) begin
        if (exp_q.size() == 0) chk("alu_unexpected", alu_valid_o, 0);
        else begin
          chk("alu_a", alu_a, exp_q[0].a);
          chk("alu_b", alu_b, exp_q[0].b);
        end
      end
      if (rsp_valid != 0) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = exp_q[0];
          chk("rsp_valid", rsp_valid, 1 << e.id);
          chk("rsp_y", rsp_y, e.y);
          chk("owner", owner, e.id);
          if (rsp_ready[e.id]) begin
            void'(exp_q.pop_front());
            n_pop++;
            n_done++;
            m_ptr = e.id;
            if (cont) own_log.push_back(e.id);
          end
        end
      end
    end
  end

  task automatic start_phase(input logic c);
    @(negedge clk);
    #2;
    rand_on = 0;
    sb_on = 0;
    req_valid = '0;
    alu_ready_i = 0;
    alu_valid_i = 0;
    rsp_ready = '0;
    alu_pend = 0;
    rst = 1;
    exp_q.delete();
    n_acc = 0;
    n_pop = 0;
    m_ptr = N - 1;
    cont = c;
    @(negedge clk);
    #2;
    rst = 0;
    sb_on = 1;
    rand_on = 1;
  endtask

  task automatic run_until(input int target);
    for (int c = 0; c < 4000 && n_done < target; c++) @(posedge clk);
    chk("timeout_done", n_done >= target, 1);
  endtask

  initial begin
    int base;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    alu_ready_i = 0; alu_valid_i = 0; alu_y = '0;
    repeat (2) step();
    rst = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_valid", alu_valid_o, 0);
    chk("rst_alu_ready", alu_ready_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_y", rsp_y, 0);
    repeat (3) step();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_req_ready", req_ready, 0);
    // single request from requester 1
    step();
    req_valid = 2'b10; req_a = 8'h30; req_b = 8'h50; alu_ready_i = 1;
    @(negedge clk);
    chk("single_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_alu_valid", alu_valid_o, 1);
    chk("single_alu_a", alu_a, 4'h3);
    chk("single_alu_b", alu_b, 4'h5);
    chk("single_owner", owner, 1);
    chk("single_busy", busy, 1);
    step();
    alu_ready_i = 0; alu_valid_i = 1; alu_y = 4'h8;
    @(negedge clk);
    chk("single_alu_ready", alu_ready_o, 1);
    step();
    alu_valid_i = 0; rsp_ready = 2'b10;
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 2'b10);
    chk("single_rsp_y", rsp_y, 4'h8);
    step();
    rsp_ready = '0;
    @(negedge clk);
    chk("single_done_valid", rsp_valid, 0);
    chk("single_done_busy", busy, 0);
    // ALU backpressure while requester 1 waits
    step();
    req_valid = 2'b01; req_a = 8'h07; req_b = 8'h02;
    @(negedge clk);
    chk("bp_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b10; req_a = 8'h67; req_b = 8'h42;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_alu_valid", alu_valid_o, 1);
      chk("bp_alu_a", alu_a, 4'h7);
      chk("bp_alu_b", alu_b, 4'h2);
      chk("bp_no_ready", req_ready, 0);
      step();
    end
    alu_ready_i = 1;
    step();
    alu_ready_i = 0; alu_valid_i = 1; alu_y = 4'h9;
    step();
    alu_valid_i = 0; rsp_ready = 2'b10;
    // response backpressure; non-owner ready is ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rbp_rsp_valid", rsp_valid, 2'b01);
      chk("rbp_rsp_y", rsp_y, 4'h9);
      chk("rbp_no_ready", req_ready, 0);
      step();
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = '0;
    @(negedge clk);
    chk("rbp_next_ready", req_ready, 2'b10);
    step();
    req_valid = '0; alu_ready_i = 1;
    step();
    alu_ready_i = 0;
    @(negedge clk);
    chk("wait_alu_ready", alu_ready_o, 1);
    chk("wait_owner", owner, 1);
    // reset during WAIT_RSP
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("mrst_alu_ready", alu_ready_o, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_owner", owner, 0);
    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    step();
    req_valid = 2'b11;
    @(negedge clk);
    chk("mrst_grant0", req_ready, 2'b01);
    step();
    req_valid = '0;
    // both requesters continuously valid: grants alternate from requester 0
    start_phase(1'b1);
    run_until(8);
    for (int i = 0; i < 4 && i < own_log.size(); i++) chk("alternate", own_log[i], i % 2);
    // randomized traffic with backpressure on both sides
    base = n_done;
    start_phase(1'b0);
    run_until(base + 40);
    rand_on = 0;
    sb_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
